// File: rtl/aes_sbox_pkg.sv
// Shared definitions for the composite-field AES S-box output mapping.
//   mode_e   : per-beat direction (MODE_ENC = 0, MODE_DEC = 1)
//   ENC_MAP  : inverse isomorphism fused with the forward affine matrix
//   DEC_MAP  : inverse isomorphism only
//   AFFINE_C : forward affine constant, applied in encrypt mode only
//   mat_mul  : GF(2) 8x8 matrix times byte
package aes_sbox_pkg;

   typedef enum logic {
      MODE_ENC = 1'b0,
      MODE_DEC = 1'b1
   } mode_e;

   localparam logic [7:0] AFFINE_C = 8'h63;

   // Entry [i] is the mask of input bits XORed together to form output bit i.
   localparam logic [7:0][7:0] ENC_MAP = {
      8'h28, 8'h88, 8'h41, 8'hA8, 8'hF8, 8'h6D, 8'h32, 8'h52
   };
   localparam logic [7:0][7:0] DEC_MAP = {
      8'h12, 8'hEB, 8'hED, 8'h42, 8'h7E, 8'hB2, 8'h22, 8'h04
   };

   function automatic logic [7:0] mat_mul(input logic [7:0][7:0] m, input logic [7:0] b);
      logic [7:0] g;
      for (int i = 0; i < 8; i++) begin
         g[i] = ^(m[i] & b);
      end
      return g;
   endfunction

endpackage

// File: rtl/gf_out_map.sv
// Combinational single-byte mapper from GF((2^4)^2) back to GF(2^8).
//   b    : composite-field input byte
//   mode : MODE_ENC applies inverse-iso plus affine, MODE_DEC inverse-iso only
//   g    : GF(2^8) output byte
module gf_out_map
   import aes_sbox_pkg::*;
(
   input  logic [7:0] b,
   input  mode_e      mode,
   output logic [7:0] g
);

   always_comb begin
      if (mode == MODE_ENC) begin
         g = mat_mul(ENC_MAP, b) ^ AFFINE_C;
      end else begin
         g = mat_mul(DEC_MAP, b);
      end
   end

endmodule

// File: rtl/sbox_out_map_pipe.sv
// Pipelined multi-lane S-box output mapper with valid/ready handshake.
// Each lane is mapped combinationally and captured into stage 0; further
// stages are plain delay registers. Empty stages accept data even when
// downstream is stalled, so bubbles collapse.
//   clk, rst           : clock, asynchronous active-high reset
//   in_valid/in_ready  : input handshake (in_ready is combinational from out_ready)
//   in_mode, in_data   : beat direction and composite-field bytes (lane i = [8i+7:8i])
//   out_valid/out_ready: output handshake
//   out_mode, out_data : carried direction and GF(2^8) bytes
// Optional build macro SBOX_MAP_ERRCHK_EN adds:
//   in_par : even parity per input lane
//   err    : sticky flag, set on any parity mismatch of an accepted beat
module sbox_out_map_pipe
   import aes_sbox_pkg::*;
#(
   parameter int unsigned LANES  = 4,
   parameter int unsigned STAGES = 1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic                 in_mode,
   input  logic [8*LANES-1:0]   in_data,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic                 out_mode,
   output logic [8*LANES-1:0]   out_data
`ifdef SBOX_MAP_ERRCHK_EN
   ,
   input  logic [LANES-1:0]     in_par,
   output logic                 err
`endif
);

   localparam int unsigned W = 8 * LANES;

   logic [W-1:0]              map_data;
   logic [STAGES-1:0]         v_q;
   logic [STAGES-1:0]         m_q;
   logic [STAGES-1:0][W-1:0]  d_q;
   logic [STAGES-1:0]         adv;

   for (genvar i = 0; i < LANES; i++) begin : g_lane
      gf_out_map u_map (
         .b    (in_data[8*i +: 8]),
         .mode (mode_e'(in_mode)),
         .g    (map_data[8*i +: 8])
      );
   end

   // Stage k can load if it or any stage after it is empty, or the consumer pops.
   // Written as an OR-reduction over v_q so adv has no self-dependency.
   always_comb begin
      adv = '0;
      for (int unsigned k = 0; k < STAGES; k++) begin
         adv[k] = out_ready;
         for (int unsigned j = k; j < STAGES; j++) begin
            if (!v_q[j]) begin
               adv[k] = 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         v_q <= '0;
         m_q <= '0;
         d_q <= '0;
      end else begin
         if (adv[0]) begin
            v_q[0] <= in_valid;
            m_q[0] <= in_mode;
            d_q[0] <= map_data;
         end
         for (int unsigned k = 1; k < STAGES; k++) begin
            if (adv[k]) begin
               v_q[k] <= v_q[k-1];
               m_q[k] <= m_q[k-1];
               d_q[k] <= d_q[k-1];
            end
         end
      end
   end

   assign in_ready  = adv[0];
   assign out_valid = v_q[STAGES-1];
   assign out_mode  = m_q[STAGES-1];
   assign out_data  = d_q[STAGES-1];

`ifdef SBOX_MAP_ERRCHK_EN
   logic             err_q;
   logic [LANES-1:0] par_bad;

   always_comb begin
      par_bad = '0;
      for (int unsigned i = 0; i < LANES; i++) begin
         par_bad[i] = in_par[i] ^ (^in_data[8*i +: 8]);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         err_q <= 1'b0;
      end else if (in_valid && adv[0] && (|par_bad)) begin
         err_q <= 1'b1;
      end
   end

   assign err = err_q;
`endif

endmodule

// File: tb/tb_sbox_out_map_pipe.sv
// Scoreboard bench for sbox_out_map_pipe: dut_a (STAGES=1) and dut_b (STAGES=3).
// Drivers push expected beats into per-DUT queues; monitors pop and compare on
// every output transfer and check output stability while stalled.
module tb_sbox_out_map_pipe;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;

   typedef struct packed {
      logic        mode;
      logic [31:0] data;
   } beat_t;

   beat_t qa[$];
   beat_t qb[$];

   // dut_a signals
   logic        a_in_valid = 1'b0, a_in_mode = 1'b0, a_out_ready = 1'b1;
   logic        a_in_ready, a_out_valid, a_out_mode;
   logic [31:0] a_in_data = '0, a_out_data;
   // dut_b signals
   logic        b_in_valid = 1'b0, b_in_mode = 1'b0, b_ordy_dir = 1'b1;
   logic        rnd_en = 1'b0, rnd_ready = 1'b1;
   logic        b_in_ready, b_out_valid, b_out_mode, b_out_ready;
   logic [31:0] b_in_data = '0, b_out_data;

   assign b_out_ready = rnd_en ? rnd_ready : b_ordy_dir;

   // Reference mapping written straight from the per-bit equations.
   function automatic logic [7:0] ref_byte(input logic [7:0] b, input logic m);
      if (!m) begin
         return {b[5]^b[3], ~(b[7]^b[3]), ~(b[6]^b[0]), b[7]^b[5]^b[3],
                 b[7]^b[6]^b[5]^b[4]^b[3], b[6]^b[5]^b[3]^b[2]^b[0],
                 ~(b[5]^b[4]^b[1]), ~(b[6]^b[4]^b[1])};
      end
      return {b[4]^b[1], b[7]^b[6]^b[5]^b[3]^b[1]^b[0], b[7]^b[6]^b[5]^b[3]^b[2]^b[0],
              b[6]^b[1], b[6]^b[5]^b[4]^b[3]^b[2]^b[1], b[7]^b[5]^b[4]^b[1],
              b[5]^b[1], b[2]};
   endfunction

   function automatic logic [31:0] ref_word(input logic [31:0] d, input logic m);
      logic [31:0] r;
      for (int i = 0; i < 4; i++) r[8*i +: 8] = ref_byte(d[8*i +: 8], m);
      return r;
   endfunction

   function automatic logic [3:0] par_of(input logic [31:0] d);
      logic [3:0] p;
      for (int i = 0; i < 4; i++) p[i] = ^d[8*i +: 8];
      return p;
   endfunction

`ifdef SBOX_MAP_ERRCHK_EN
   logic [3:0] a_par_flip = '0;
   logic [3:0] a_in_par, b_in_par;
   logic       a_err, b_err;
   assign a_in_par = par_of(a_in_data) ^ a_par_flip;
   assign b_in_par = par_of(b_in_data);
`endif

   sbox_out_map_pipe #(.LANES(4), .STAGES(1)) dut_a (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (a_in_valid),
      .in_ready  (a_in_ready),
      .in_mode   (a_in_mode),
      .in_data   (a_in_data),
      .out_valid (a_out_valid),
      .out_ready (a_out_ready),
      .out_mode  (a_out_mode),
      .out_data  (a_out_data)
`ifdef SBOX_MAP_ERRCHK_EN
      ,
      .in_par    (a_in_par),
      .err       (a_err)
`endif
   );

   sbox_out_map_pipe #(.LANES(4), .STAGES(3)) dut_b (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (b_in_valid),
      .in_ready  (b_in_ready),
      .in_mode   (b_in_mode),
      .in_data   (b_in_data),
      .out_valid (b_out_valid),
      .out_ready (b_out_ready),
      .out_mode  (b_out_mode),
      .out_data  (b_out_data)
`ifdef SBOX_MAP_ERRCHK_EN
      ,
      .in_par    (b_in_par),
      .err       (b_err)
`endif
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (rnd_en) rnd_ready = 1'($urandom_range(0, 1));
   end

   // Monitors: sample mid-cycle; a beat with valid & ready transfers on the next posedge.
   logic  a_hold = 1'b0, b_hold = 1'b0;
   beat_t a_prev, b_prev, a_exp, b_exp;

   always @(negedge clk) begin
      #2;
      if (rst) begin
         a_hold = 1'b0;
      end else begin
         if (a_hold) check("a_stall_stable", {a_out_valid, a_out_mode, a_out_data}, {1'b1, a_prev});
         if (a_out_valid && a_out_ready) begin
            if (qa.size() == 0) begin
               tests++; fails++;
               $display("FAIL a_spurious_beat: got %0h, expected no beat", a_out_data);
            end else begin
               a_exp = qa.pop_front();
               check("a_out_beat", {a_out_mode, a_out_data}, a_exp);
            end
         end
         a_hold = a_out_valid && !a_out_ready;
         a_prev = {a_out_mode, a_out_data};
      end
   end

   always @(negedge clk) begin
      #2;
      if (rst) begin
         b_hold = 1'b0;
      end else begin
         if (b_hold) check("b_stall_stable", {b_out_valid, b_out_mode, b_out_data}, {1'b1, b_prev});
         if (b_out_valid && b_out_ready) begin
            if (qb.size() == 0) begin
               tests++; fails++;
               $display("FAIL b_spurious_beat: got %0h, expected no beat", b_out_data);
            end else begin
               b_exp = qb.pop_front();
               check("b_out_beat", {b_out_mode, b_out_data}, b_exp);
            end
         end
         b_hold = b_out_valid && !b_out_ready;
         b_prev = {b_out_mode, b_out_data};
      end
   end

   // Presents one beat to dut_b and returns just after the accepting edge; in_valid stays high.
   task automatic send_b(input logic m, input logic [31:0] d, input logic [31:0] exp);
      int n = 0;
      @(negedge clk);
      b_in_valid = 1'b1; b_in_mode = m; b_in_data = d;
      #1;
      while (!b_in_ready && n < 200) begin
         @(negedge clk); #1; n++;
      end
      if (!b_in_ready) begin
         tests++; fails++;
         $display("FAIL b_send_timeout: got in_ready 0, expected 1 within 200 cycles");
      end else begin
         qb.push_back({m, exp});
      end
      @(posedge clk);
   endtask

   task automatic drain_b();
      int n = 0;
      while (qb.size() != 0 && n < 500) begin
         @(negedge clk); n++;
      end
      check("b_drain_empty", qb.size(), 0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout, expected $finish");
      $fatal(1, "watchdog");
   end

   logic [31:0] rd;
   logic        rm;

   initial begin
      // Reset state
      @(negedge clk); #1;
      check("a_rst_out_valid", a_out_valid, 0);
      check("a_rst_out_data", a_out_data, 0);
      check("a_rst_out_mode", a_out_mode, 0);
      check("a_rst_in_ready", a_in_ready, 1);
      check("b_rst_out_valid", b_out_valid, 0);
      check("b_rst_in_ready", b_in_ready, 1);
      @(negedge clk); rst = 1'b0;

      // dut_a: encrypt then decrypt beat, one-cycle latency
      @(negedge clk);
      a_in_valid = 1'b1; a_in_mode = 1'b0; a_in_data = 32'h00FF00FF; #1;
      check("a_enc_in_ready", a_in_ready, 1);
      check("a_pre_out_valid", a_out_valid, 0);
      qa.push_back({1'b0, 32'h637C637C});
      @(posedge clk); #1;
      check("a_latency_valid", a_out_valid, 1);
      check("a_enc_mode", a_out_mode, 0);
      @(negedge clk);
      a_in_mode = 1'b1; a_in_data = 32'hFF00FF00;
      qa.push_back({1'b1, 32'h01000100});
      @(posedge clk); #1;
      check("a_dec_mode", a_out_mode, 1);
      check("a_dec_data", a_out_data, 32'h01000100);
      @(negedge clk); a_in_valid = 1'b0;
      @(negedge clk); #1;
      check("a_idle_valid", a_out_valid, 0);

      // dut_b: fill with out_ready low, then release
      b_ordy_dir = 1'b0;
      send_b(1'b0, 32'h00FF00FF, 32'h637C637C);
      send_b(1'b1, 32'hFF00FF00, 32'h01000100);
      send_b(1'b0, 32'h00000000, 32'h63636363);
      @(negedge clk);
      b_in_mode = 1'b1; b_in_data = 32'hFFFFFFFF; #1;
      check("b_full_in_ready", b_in_ready, 0);
      check("b_full_out_valid", b_out_valid, 1);
      repeat (3) @(negedge clk);
      #1;
      check("b_stall_in_ready", b_in_ready, 0);
      @(negedge clk);
      b_ordy_dir = 1'b1; #1;
      check("b_comb_in_ready", b_in_ready, 1);
      qb.push_back({1'b1, 32'h01010101});
      @(posedge clk);
      @(negedge clk);
      b_ordy_dir = 1'b0; b_in_valid = 1'b0; #1;
      check("b_occupancy_kept", b_in_ready, 0);
      @(negedge clk);
      b_ordy_dir = 1'b1;
      send_b(1'b0, 32'hFFFFFFFF, 32'h7C7C7C7C);
      @(negedge clk); b_in_valid = 1'b0;
      drain_b();

      // Reset with two beats in flight
      b_ordy_dir = 1'b0;
      send_b(1'b0, 32'h12345678, ref_word(32'h12345678, 1'b0));
      send_b(1'b1, 32'h9ABCDEF0, ref_word(32'h9ABCDEF0, 1'b1));
      @(negedge clk); b_in_valid = 1'b0;
      repeat (3) @(negedge clk);
      #1;
      check("b_pre_rst_valid", b_out_valid, 1);
      rst = 1'b1; #1;
      check("b_rst_async_valid", b_out_valid, 0);
      check("b_rst_async_ready", b_in_ready, 1);
      qb.delete();
      @(negedge clk); rst = 1'b0; b_ordy_dir = 1'b1;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk); #1;
         check("b_no_stale_beat", b_out_valid, 0);
      end

      // Random stream against the reference model with random backpressure
      rnd_en = 1'b1;
      for (int i = 0; i < 1000; i++) begin
         rd = $urandom;
         rm = 1'($urandom_range(0, 1));
         if ($urandom_range(0, 3) == 0) begin
            @(negedge clk); b_in_valid = 1'b0;
         end
         send_b(rm, rd, ref_word(rd, rm));
      end
      @(negedge clk); b_in_valid = 1'b0;
      drain_b();
      rnd_en = 1'b0;

`ifdef SBOX_MAP_ERRCHK_EN
      @(negedge clk); rst = 1'b1; #1;
      check("a_err_rst", a_err, 0);
      @(negedge clk); rst = 1'b0;
      @(negedge clk);
      a_in_valid = 1'b1; a_in_mode = 1'b0; a_in_data = 32'h00FF00FF; a_par_flip = 4'b0100;
      qa.push_back({1'b0, 32'h637C637C});
      @(negedge clk);
      a_par_flip = 4'b0000; a_in_data = 32'h00000000;
      qa.push_back({1'b0, 32'h63636363});
      #1;
      check("a_err_set", a_err, 1);
      @(negedge clk); a_in_valid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk); #1;
         check("a_err_sticky", a_err, 1);
      end
      rst = 1'b1; #1;
      check("a_err_cleared", a_err, 0);
      @(negedge clk); rst = 1'b0;
`endif

      repeat (3) @(negedge clk);
      check("a_queue_empty", qa.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/sbox_out_map_pipe.md
# sbox_out_map_pipe

Pipelined, multi-lane output mapper for the composite-field AES S-box datapath. Each lane takes a byte out of the GF((2^4)^2) inverter and maps it back to GF(2^8). Encrypt mode applies the inverse isomorphism fused with the forward affine transform. Decrypt mode applies the inverse isomorphism only. The block sits between the composite-field inverter and the round/key-schedule consumers, with a valid/ready stream handshake and a configurable register depth.

## Interface
- LANES, default 4: number of independent byte lanes (1..16).
- STAGES, default 1: register stages from input to output (1..4).
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous reset, active-high.
- in_valid  input  1  input beat present.
- in_ready  output  1  block accepts the beat this cycle.
- in_mode  input  1  0 = encrypt (inverse-iso + affine), 1 = decrypt (inverse-iso only); applies to all lanes of the beat.
- in_data  input  8*LANES  composite-field bytes; lane i is [8i+7:8i].
- out_valid  output  1  output beat present.
- out_ready  input  1  consumer accepts this cycle.
- out_mode  output  1  in_mode carried with the beat.
- out_data  output  8*LANES  GF(2^8) bytes, same lane order.

## Operation
- Per lane, input b to output g, with ^ denoting XOR:
  - Encrypt:
    - g7=b5^b3
    - g6=~(b7^b3)
    - g5=~(b6^b0)
    - g4=b7^b5^b3
    - g3=b7^b6^b5^b4^b3
    - g2=b6^b5^b3^b2^b0
    - g1=~(b5^b4^b1)
    - g0=~(b6^b4^b1)
  - Decrypt:
    - g7=b4^b1
    - g6=b7^b6^b5^b3^b1^b0
    - g5=b7^b6^b5^b3^b2^b0
    - g4=b6^b1
    - g3=b6^b5^b4^b3^b2^b1
    - g2=b7^b5^b4^b1
    - g1=b5^b1
    - g0=b2
- Mapping is combinational on in_data and is captured into stage 0. Stages 1..STAGES-1 are pure delay registers carrying {valid, mode, data}.
- Stage k loads when empty or when its contents move on: adv[k] = !v[k] | adv[k+1]. The last stage uses adv = !v[last] | out_ready.
- in_ready = adv[0]. A beat transfers when in_valid & in_ready.
- The pipeline collapses bubbles: an empty stage accepts data even when stages downstream are stalled.
- No beat is dropped, duplicated or reordered. out_mode always matches the beat's in_mode.

## Timing
- Reset state, held while rst is high: all stage valids 0, data 0, mode 0. Therefore out_valid=0, out_data=0, out_mode=0, in_ready=1.
- Reset asserted mid-stream discards all in-flight beats immediately (asynchronous). First acceptance is on the first clk edge after rst falls.
- Latency is STAGES cycles from accepted beat to out_valid, with out_ready held high. Throughput is 1 beat/cycle.
- While out_valid & !out_ready, out_data and out_mode are held stable.
- Full pipeline with out_ready=0: in_ready=0 in the same cycle, combinationally from out_ready.
- Simultaneous output pop and input push on a full pipeline: both occur in that cycle, and occupancy stays constant.
- in_ready depends combinationally on out_ready. No combinational path from in_data to out_data.

## Configuration
- SBOX_MAP_ERRCHK_EN defined: adds the ports
  - in_par  input  LANES: even parity of each in_data lane.
  - err  output  1: sticky error flag.
- Parity is checked on each accepted beat. Any lane mismatch sets err on the next edge. err stays set until rst. Reset value 0.
- Data still flows unchanged on a parity error.
- Undefined: neither port exists and no check logic is built. Datapath behaviour is identical in both builds.

## Structure
- Shared package aes_sbox_pkg:
  - mode typedef (MODE_ENC=0, MODE_DEC=1).
  - 8x8 encrypt and decrypt map matrices as constants.
  - affine constant 8'h63.
- Sub-module gf_out_map: combinational single-byte mapper (b, mode → g), instantiated LANES times.
- Top level holds the stage registers and the handshake.

## Test plan
- Reset, then LANES=4, STAGES=1: encrypt beat in_data=32'h00FF00FF → out_data=32'h637C637C, out_valid one cycle later, out_mode=0.
- Decrypt beat in_data=32'hFF00FF00 → out_data=32'h01000100, out_mode=1.
- STAGES=3, out_ready=0, stream 5 beats:
  - in_ready drops after 3 accepted beats.
  - After out_ready rises, all 5 beats emerge in order, alternating modes preserved.
- out_ready toggled randomly over 1000 random beats:
  - output matches a reference model lane-by-lane.
  - out_data stable whenever out_valid & !out_ready.
- rst pulsed with 2 beats in flight → out_valid=0 immediately; no stale beat appears after release.
- SBOX_MAP_ERRCHK_EN: beat with lane 2 parity wrong → err=1 next cycle; err stays 1 through later good beats until rst.
